// File: rtl/gcd_stein_seq.sv
// rtl/gcd_stein_seq.sv - sequential binary (Stein) GCD engine with valid/ready handshakes
// One Stein step per clock; a single operand pair is in flight at a time.
module gcd_stein_seq #(
  parameter  int WIDTH = 8,
  localparam int KW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] P,
  input  logic [WIDTH-1:0] Q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] R,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_REDUCE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_r;

  logic             w_zero_in;
  logic             w_both_even;
  logic             w_term;
  logic [WIDTH-1:0] w_a_minus_b;
  logic [WIDTH-1:0] w_b_minus_a;
  logic [WIDTH-1:0] w_result;

  assign w_zero_in   = (P == '0) || (Q == '0);
  assign w_both_even = !r_a[0] && !r_b[0];
  assign w_term      = (r_a == '0) || (r_b == '0);
  assign w_a_minus_b = r_a - r_b;
  assign w_b_minus_a = r_b - r_a;
  // The common power of two was stripped out of both operands, so this cannot overflow.
  assign w_result    = (r_a | r_b) << r_k;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign R         = r_r;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (in_valid) w_next = w_zero_in ? S_DONE : S_SHIFT;
      S_SHIFT:  if (!w_both_even) w_next = S_REDUCE;
      S_REDUCE: if (w_term) w_next = S_DONE;
      S_DONE:   if (out_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_a <= '0;
      r_b <= '0;
      r_k <= '0;
      r_r <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a <= P;
            r_b <= Q;
            r_k <= '0;
            if (w_zero_in) r_r <= P | Q;
          end
        end
        S_SHIFT: begin
          if (w_both_even) begin
            r_a <= r_a >> 1;
            r_b <= r_b >> 1;
            r_k <= r_k + KW'(1);
          end
        end
        S_REDUCE: begin
          // Subtract only larger-minus-smaller; the difference of two odds is even, hence the shift.
          if (w_term)            r_r <= w_result;
          else if (!r_a[0])      r_a <= r_a >> 1;
          else if (!r_b[0])      r_b <= r_b >> 1;
          else if (r_a >= r_b)   r_a <= w_a_minus_b >> 1;
          else                   r_b <= w_b_minus_a >> 1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_stein_seq.sv
// tb/tb_gcd_stein_seq.sv - scoreboard bench for gcd_stein_seq at WIDTH 8 and 16
// Drivers push expected results; negedge monitors pop and compare on each output handshake.
module tb_gcd_stein_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        iv8 = 1'b0, rdy8, ov8, or8 = 1'b1, busy8;
  logic [7:0]  p8 = '0, q8v = '0, r8;
  logic        iv16 = 1'b0, rdy16, ov16, or16 = 1'b1, busy16;
  logic [15:0] p16 = '0, q16v = '0, r16;

  int tests = 0;
  int fails = 0;
  int exp8_q[$];
  int exp16_q[$];

  always #5 clk = ~clk;

  gcd_stein_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8), .P(p8), .Q(q8v),
    .out_valid(ov8), .out_ready(or8), .R(r8), .busy(busy8)
  );

  gcd_stein_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(rdy16), .P(p16), .Q(q16v),
    .out_valid(ov16), .out_ready(or16), .R(r16), .busy(busy16)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  always @(negedge clk) begin
    if (rst && ov8 && or8) begin
      if (exp8_q.size() == 0) check("unexpected_result8", int'(r8), -1);
      else check("result8", int'(r8), exp8_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst && ov16 && or16) begin
      if (exp16_q.size() == 0) check("unexpected_result16", int'(r16), -1);
      else check("result16", int'(r16), exp16_q.pop_front());
    end
  end

  task automatic issue8(input int p, input int q, input int exp, input bit push);
    int wt;
    int lat;
    wt = 0;
    while (!rdy8 && wt < 200) begin @(posedge clk); #1; wt++; end
    check("in_ready_before_accept8", int'(rdy8), 1);
    p8 = p[7:0]; q8v = q[7:0]; iv8 = 1'b1;
    if (push) exp8_q.push_back(exp);
    @(posedge clk); #1;
    iv8 = 1'b0;
    check("in_ready_low_busy8", int'(rdy8), 0);
    check("busy_high8", int'(busy8), 1);
    if (!push) return;
    lat = 1;
    while (!ov8 && lat <= 3*8+2) begin @(posedge clk); #1; lat++; end
    check("out_valid_seen8", int'(ov8), 1);
    if (p == 0 || q == 0) check("zero_latency8", lat, 1);
    else check("latency_bound8", int'(lat <= 3*8+2), 1);
    if (or8) begin
      wt = 0;
      while (ov8 && wt < 100) begin @(posedge clk); #1; wt++; end
      check("handshake_done8", int'(ov8), 0);
    end
  endtask

  task automatic issue16(input int p, input int q, input int exp);
    int wt;
    int lat;
    wt = 0;
    while (!rdy16 && wt < 200) begin @(posedge clk); #1; wt++; end
    check("in_ready_before_accept16", int'(rdy16), 1);
    p16 = p[15:0]; q16v = q[15:0]; iv16 = 1'b1;
    exp16_q.push_back(exp);
    @(posedge clk); #1;
    iv16 = 1'b0;
    lat = 1;
    while (!ov16 && lat <= 3*16+2) begin @(posedge clk); #1; lat++; end
    check("out_valid_seen16", int'(ov16), 1);
    if (p == 0 || q == 0) check("zero_latency16", lat, 1);
    else check("latency_bound16", int'(lat <= 3*16+2), 1);
    wt = 0;
    while (ov16 && wt < 100) begin @(posedge clk); #1; wt++; end
    check("handshake_done16", int'(ov16), 0);
  endtask

  initial begin
    int pa, qa, wt;
    int vec [9][3] = '{'{8,4,4}, '{4,0,4}, '{0,0,0}, '{0,129,129}, '{67,9,1},
                       '{100,25,25}, '{25,100,25}, '{120,10,10}, '{136,132,4}};

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", int'(rdy8), 1);
    check("reset_out_valid", int'(ov8), 0);
    check("reset_busy", int'(busy8), 0);
    check("reset_R", int'(r8), 0);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) issue8(vec[i][0], vec[i][1], vec[i][2], 1'b1);
    issue8(136, 64, 8, 1'b1);
    issue8(255, 255, 255, 1'b1);
    issue8(128, 192, 64, 1'b1);

    or8 = 1'b0;
    issue8(10, 4, 2, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp_out_valid_held", int'(ov8), 1);
      check("bp_R_stable", int'(r8), 2);
      check("bp_in_ready_low", int'(rdy8), 0);
    end
    or8 = 1'b1;
    @(posedge clk); #1;
    check("bp_released", int'(ov8), 0);
    check("bp_R_kept", int'(r8), 2);

    issue8(67, 9, 1, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_in_ready", int'(rdy8), 1);
    check("abort_out_valid", int'(ov8), 0);
    check("abort_busy", int'(busy8), 0);
    check("abort_R", int'(r8), 0);
    rst = 1'b1;
    issue8(3, 3, 3, 1'b1);

    issue16(65535, 255, 255);
    issue16(32768, 49152, 16384);
    issue16(0, 40000, 40000);
    for (int i = 0; i < 200; i++) begin
      pa = int'($urandom_range(0, 65535));
      qa = int'($urandom_range(0, 65535));
      if (i % 4 == 0) begin
        pa = (pa & 16'h00ff) << 6;
        qa = (qa & 16'h03ff) << 6;
      end
      issue16(pa, qa, ref_gcd(pa, qa));
    end

    wt = 0;
    while ((exp8_q.size() != 0 || exp16_q.size() != 0) && wt < 100) begin
      @(posedge clk); #1; wt++;
    end
    check("scoreboard8_drained", exp8_q.size(), 0);
    check("scoreboard16_drained", exp16_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
